// File: rtl/peripheral_msi_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the AHB3-to-APB4 bridge state type.
package peripheral_msi_ahb3_pkg;

    // HTRANS codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE codes (transfer width in bits)
    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    // HRESP codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bridge sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } bridge_state_t;

endpackage

// File: rtl/peripheral_msi_apb4_strb_gen.sv
// Byte-strobe generator: a run of 2^hsize ones placed at the byte lane
// selected by the address LSBs; bytes that would fall past the top lane are dropped.
module peripheral_msi_apb4_strb_gen #(
    parameter int XLEN = 64,
    parameter int AW   = $clog2(XLEN/8)
) (
    input  logic [2:0]        hsize,
    input  logic [AW-1:0]     addr_lsb,
    output logic [XLEN/8-1:0] pstrb
);

    localparam int NB = XLEN/8;

    logic [NB-1:0] mask;

    // Build the unshifted lane mask, then move it to the addressed lane
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (32'd1 << hsize)) begin
                mask[i] = 1'b1;
            end
        end
        pstrb = mask << addr_lsb;
    end

endmodule

// File: rtl/peripheral_msi_bridge_ahb3_apb4.sv
// AHB3-Lite slave to APB4 master bridge. Every accepted AHB transfer is turned
// into exactly one APB4 transfer; the AHB side is stalled with HREADYOUT=0.
//
// Handshakes: an AHB transfer is accepted when HSEL & HREADY & HTRANS is
// NONSEQ/SEQ while HREADYOUT=1 (states IDLE, DONE, ERR2). On APB, one transfer
// is SETUP (PSEL=1, PENABLE=0) for one cycle followed by ACCESS (PSEL=1,
// PENABLE=1) until PREADY=1; PSLVERR is only looked at when PREADY=1.
module peripheral_msi_bridge_ahb3_apb4
    import peripheral_msi_ahb3_pkg::*;
#(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int PADDR_SIZE = 32
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  HSEL,
    input  logic [PLEN-1:0]       HADDR,
    input  logic [XLEN-1:0]       HWDATA,
    output logic [XLEN-1:0]       HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [XLEN-1:0]       PWDATA,
    output logic [XLEN/8-1:0]     PSTRB,
    output logic [2:0]            PPROT,
    input  logic [XLEN-1:0]       PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output bridge_state_t         dbg_state
);

    localparam int         AW        = $clog2(XLEN/8);
    localparam logic [2:0] MAX_HSIZE = 3'(AW);

    bridge_state_t     state;
    logic              accept;
    logic              size_err;
    logic [XLEN/8-1:0] strb_next;
    logic              unused_ok;

    // Burst type, lock and cacheable/bufferable bits carry no meaning on APB
    assign unused_ok = &{1'b0, HBURST, HMASTLOCK, HPROT[3:2], HADDR};

    assign accept    = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ))
                       & HREADYOUT;
    assign size_err  = (HSIZE > MAX_HSIZE);
    assign dbg_state = state;

    peripheral_msi_apb4_strb_gen #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_strb_gen (
        .hsize    (HSIZE),
        .addr_lsb (HADDR[AW-1:0]),
        .pstrb    (strb_next)
    );

    // Bridge sequencer; every bus output is a register set on state entry
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept) begin
                        // Address phase: latch everything APB needs up front
                        PADDR     <= HADDR[PADDR_SIZE-1:0];
                        PWRITE    <= HWRITE;
                        PSTRB     <= HWRITE ? strb_next : '0;
                        PPROT     <= {~HPROT[0], 1'b1, HPROT[1]};
                        HREADYOUT <= 1'b0;
                        if (size_err) begin
                            // Too wide for the data path: no APB access at all
                            HRESP <= HRESP_ERROR;
                            state <= ST_ERR1;
                        end else if (HWRITE) begin
                            HRESP <= HRESP_OKAY;
                            state <= ST_WDATA;
                        end else begin
                            HRESP <= HRESP_OKAY;
                            PSEL  <= 1'b1;
                            state <= ST_SETUP;
                        end
                    end else begin
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                        state     <= ST_IDLE;
                    end
                end

                ST_WDATA: begin
                    // HWDATA is valid in the data phase, one cycle after accept
                    PWDATA <= HWDATA;
                    PSEL   <= 1'b1;
                    state  <= ST_SETUP;
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            HRESP <= HRESP_ERROR;
                            state <= ST_ERR1;
                        end else begin
                            if (!PWRITE) begin
                                HRDATA <= PRDATA;
                            end
                            HREADYOUT <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end

                ST_ERR1: begin
                    // Second cycle of the two-cycle AHB ERROR response
                    HREADYOUT <= 1'b1;
                    state     <= ST_ERR2;
                end

                default: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_msi_bridge_ahb3_apb4.sv
// Self-checking bench for the AHB3-Lite to APB4 bridge.
module tb_peripheral_msi_bridge_ahb3_apb4;
    import peripheral_msi_ahb3_pkg::*;

    logic              HRESETn;
    logic              HCLK;
    logic              HSEL;
    logic [63:0]       HADDR;
    logic [63:0]       HWDATA;
    logic [63:0]       HRDATA;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic              HMASTLOCK;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic              PSEL;
    logic              PENABLE;
    logic [31:0]       PADDR;
    logic              PWRITE;
    logic [63:0]       PWDATA;
    logic [7:0]        PSTRB;
    logic [2:0]        PPROT;
    logic [63:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    bridge_state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: read data expected back on HRDATA, in completion order
    logic [63:0] exp_q[$];
    logic [63:0] last_rd = '0;

    peripheral_msi_bridge_ahb3_apb4 #(
        .PLEN(64), .XLEN(64), .PADDR_SIZE(32)
    ) dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
    );

    // Clock
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference strobe: 2^size bytes starting at the addressed lane, clipped to 8 lanes
    function automatic logic [7:0] model_strb(input logic wr, input logic [2:0] size,
                                              input logic [63:0] addr);
        int bytes;
        int lane;
        logic [7:0] s;
        s = '0;
        if (wr) begin
            bytes = 1 << size;
            lane  = int'(addr % 8);
            for (int b = 0; b < bytes; b++) begin
                if (lane + b < 8) s[lane + b] = 1'b1;
            end
        end
        return s;
    endfunction

    // Driver plus APB slave: one AHB transfer, observed cycle by cycle
    task automatic ahb_xfer(input logic wr, input logic [63:0] addr, input logic [2:0] size,
                            input logic [3:0] prot, input logic [63:0] data,
                            input int nwait, input logic slverr);
        logic        size_err;
        logic        err;
        int          lat;
        int          exp_done;
        int          exp_err1;
        int          done_cyc;
        int          err1_cyc;
        int          setup_cyc;
        int          nps;
        int          npe;
        int          acc;
        int          bad;
        logic        resp_at_done;
        logic [107:0] snap;

        size_err = (size > 3);
        err      = size_err || slverr;
        lat      = size_err ? 0 : (wr ? 1 : 0) + 2 + nwait;
        exp_done = lat + 1 + (err ? 1 : 0);
        exp_err1 = err ? lat + 1 : 0;
        if (!wr && !err) exp_q.push_back(data);

        // Address phase
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr;
        HSIZE = size; HPROT = prot; HREADY = 1'b1;
        HBURST = 3'($urandom_range(0, 7)); HMASTLOCK = 1'($urandom_range(0, 1));
        @(negedge HCLK);
        check_eq("idle_ready", HREADYOUT, 1'b1);
        check_eq("idle_resp", HRESP, 1'b0);
        check_eq("idle_psel", PSEL, 1'b0);

        // Data phase onwards
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = wr ? data : {$urandom, $urandom};
        done_cyc = 0; err1_cyc = 0; setup_cyc = 0; nps = 0; npe = 0; acc = 0; bad = 0;
        resp_at_done = 1'b0; snap = '0;
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            @(negedge HCLK);
            if (PSEL) begin
                nps++;
                if (PENABLE) npe++;
                if (setup_cyc == 0) begin
                    setup_cyc = cyc;
                    snap = {PADDR, PWRITE, PSTRB, PPROT, PWDATA};
                    check_eq("paddr", PADDR, addr[31:0]);
                    check_eq("pwrite", PWRITE, wr);
                    check_eq("pstrb", PSTRB, model_strb(wr, size, addr));
                    check_eq("pprot", PPROT, {~prot[0], 1'b1, prot[1]});
                    if (wr) check_eq("pwdata", PWDATA, data);
                end else if ({PADDR, PWRITE, PSTRB, PPROT, PWDATA} !== snap) begin
                    bad++;
                end
            end
            if (HRESP && !HREADYOUT && err1_cyc == 0) err1_cyc = cyc;
            if (HREADYOUT) begin
                done_cyc = cyc;
                resp_at_done = HRESP;
            end
            if (PSEL && PENABLE) begin
                acc++;
                PREADY  = (acc > nwait);
                PSLVERR = slverr && PREADY;
                PRDATA  = PREADY ? data : ~data;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;

        check_eq("done_cycle", done_cyc, exp_done);
        check_eq("resp_at_done", resp_at_done, err);
        check_eq("err1_cycle", err1_cyc, exp_err1);
        check_eq("psel_cycles", nps, size_err ? 0 : 2 + nwait);
        check_eq("penable_cycles", npe, size_err ? 0 : 1 + nwait);
        if (!size_err) check_eq("setup_cycle", setup_cyc, wr ? 2 : 1);
        check_eq("apb_stable", bad, 0);
        if (!wr && !err && exp_q.size() > 0) last_rd = exp_q.pop_front();
        check_eq("hrdata", HRDATA, last_rd);
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = '0; HBURST = '0; HPROT = '0; HTRANS = HTRANS_IDLE; HMASTLOCK = 1'b0;
        HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        // Reset
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("rst_ready", HREADYOUT, 1'b1);
        check_eq("rst_resp", HRESP, 1'b0);
        check_eq("rst_hrdata", HRDATA, 64'h0);
        check_eq("rst_apb", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, 64'h0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        HRESETn = 1'b1;

        // Directed cases
        ahb_xfer(1'b0, 64'h0000_0000_1000_0008, 3'd3, 4'b0011, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
        ahb_xfer(1'b1, 64'h0000_0000_0000_0004, 3'd2, 4'b0000, 64'hAAAA_BBBB_0000_0000, 0, 1'b0);
        ahb_xfer(1'b0, 64'h0000_0000_2000_0010, 3'd3, 4'b0010, 64'h1122_3344_5566_7788, 3, 1'b0);
        ahb_xfer(1'b1, 64'h0000_0000_3000_0000, 3'd3, 4'b0001, 64'h0F0F_0F0F_0F0F_0F0F, 1, 1'b1);
        ahb_xfer(1'b0, 64'h0000_0000_4000_0000, 3'd4, 4'b0001, 64'h5555_5555_5555_5555, 0, 1'b0);
        ahb_xfer(1'b1, 64'h0000_0000_4000_0007, 3'd1, 4'b0001, 64'h1234_0000_0000_0000, 0, 1'b0);

        // BUSY with HSEL is a zero-wait OKAY with no APB activity
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check_eq("busy_ready", HREADYOUT, 1'b1);
            check_eq("busy_resp", HRESP, 1'b0);
            check_eq("busy_psel", PSEL, 1'b0);
        end
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;

        // Reset while the APB slave is stalling in ACCESS
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 64'h50; HWRITE = 1'b0; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        for (int i = 0; i < 10 && !(PSEL && PENABLE); i++) @(negedge HCLK);
        check_eq("rst_reached_access", PSEL && PENABLE, 1'b1);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        check_eq("rst_mid_psel", PSEL, 1'b0);
        check_eq("rst_mid_penable", PENABLE, 1'b0);
        check_eq("rst_mid_ready", HREADYOUT, 1'b1);
        check_eq("rst_mid_hrdata", HRDATA, 64'h0);
        HRESETn = 1'b1;
        exp_q.delete();
        last_rd = '0;
        ahb_xfer(1'b0, 64'h0000_0000_6000_0018, 3'd3, 4'b0000, 64'hCAFE_F00D_8765_4321, 0, 1'b0);

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            ahb_xfer(1'($urandom_range(0, 1)), {$urandom, $urandom},
                     3'(($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), {$urandom, $urandom},
                     $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
